// File: rtl/crossing_request_if.sv
// Signals between the crossing button, the light controller and crossing_request.
// master is the board/controller side; slave is the request generator.
interface crossing_request_if;
  logic raw_btn;
  logic red_light;
  logic yellow_light;
  logic green_light;
  logic start_btn;
  logic req_pending;
  logic busy;
  logic light_fault;

  modport master (
    output raw_btn, red_light, yellow_light, green_light,
    input  start_btn, req_pending, busy, light_fault
  );

  modport slave (
    input  raw_btn, red_light, yellow_light, green_light,
    output start_btn, req_pending, busy, light_fault
  );
endinterface

// File: rtl/crossing_request.sv
// Pedestrian request generator: debounces the crossing button, latches a request and
// issues a start_btn pulse after a minimum stable red, then tracks the light cycle.
module crossing_request #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MIN_RED_CYCLES  = 200_000_000,
  parameter int PULSE_CYCLES    = 4,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  crossing_request_if.slave io
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW_W = $clog2(MIN_RED_CYCLES + 1);
  localparam int PC_W = $clog2(PULSE_CYCLES + 1);
  localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_FULL = DW_W'(MIN_RED_CYCLES);
  localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    PULSE      = 3'd2,
    WAIT_GREEN = 3'd3,
    CYCLE      = 3'd4
  } state_t;

  function automatic logic multi_hot(input logic r, input logic y, input logic g);
    return (r & y) | (r & g) | (y & g);
  endfunction

  logic            sync1_q, sync1_d;
  logic            btn_s_q, btn_s_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q, btn_db_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [PC_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            req_pending_q, req_pending_d;
  logic            light_fault_q, light_fault_d;
  logic            start_btn_q, start_btn_d;
  logic            busy_q, busy_d;
  state_t          state_q, state_d, state_nat_s;

  logic red_only_s;
  logic timeout_s;
  logic rise_s;

  assign red_only_s = io.red_light & ~io.yellow_light & ~io.green_light;
  assign timeout_s  = (state_q == WAIT_GREEN) & ~io.green_light & (wait_cnt_q == WAIT_LAST);
  assign rise_s     = btn_db_q & ~btn_db_prev_q;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (btn_s_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Dwell restarts during CYCLE and after an unacknowledged pulse so every issue sees a full red.
  always_comb begin
    dwell_d = dwell_q;
    if ((state_q == CYCLE) || timeout_s || !red_only_s) begin
      dwell_d = '0;
    end else if (dwell_q == DWELL_FULL) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DW_W'(1);
    end
  end

  always_comb begin
    state_nat_s = state_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_pending_q && (dwell_d == DWELL_FULL)) state_nat_s = ARMED;
        else                                          state_nat_s = IDLE;
      end
      ARMED: begin
        if (red_only_s) begin
          state_nat_s = PULSE;
          pulse_cnt_d = '0;
        end else begin
          state_nat_s = IDLE;
        end
      end
      PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_nat_s = WAIT_GREEN;
          wait_cnt_d  = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end
      end
      WAIT_GREEN: begin
        if (io.green_light)  state_nat_s = CYCLE;
        else if (timeout_s)  state_nat_s = IDLE;
        else                 wait_cnt_d  = wait_cnt_q + WC_W'(1);
      end
      CYCLE: begin
        if (red_only_s) state_nat_s = IDLE;
        else            state_nat_s = CYCLE;
      end
      default: state_nat_s = IDLE;
    endcase
    if (light_fault_q) state_d = IDLE;
    else               state_d = state_nat_s;
  end

  // A new button edge wins over the acknowledge clear in the same cycle.
  always_comb begin
    sync1_d       = io.raw_btn;
    btn_s_d       = sync1_q;
    btn_db_prev_d = btn_db_q;
    start_btn_d   = (state_d == PULSE);
    busy_d        = (state_d == PULSE) || (state_d == WAIT_GREEN) || (state_d == CYCLE);
    light_fault_d = light_fault_q | multi_hot(io.red_light, io.yellow_light, io.green_light);
    if (rise_s)                                             req_pending_d = 1'b1;
    else if ((state_q == WAIT_GREEN) && (state_d == CYCLE)) req_pending_d = 1'b0;
    else                                                    req_pending_d = req_pending_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      btn_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      dwell_q       <= '0;
      pulse_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      req_pending_q <= 1'b0;
      light_fault_q <= 1'b0;
      start_btn_q   <= 1'b0;
      busy_q        <= 1'b0;
      state_q       <= IDLE;
    end else begin
      sync1_q       <= sync1_d;
      btn_s_q       <= btn_s_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      db_cnt_q      <= db_cnt_d;
      dwell_q       <= dwell_d;
      pulse_cnt_q   <= pulse_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      req_pending_q <= req_pending_d;
      light_fault_q <= light_fault_d;
      start_btn_q   <= start_btn_d;
      busy_q        <= busy_d;
      state_q       <= state_d;
    end
  end

  assign io.start_btn   = start_btn_q;
  assign io.req_pending = req_pending_q;
  assign io.busy        = busy_q;
  assign io.light_fault = light_fault_q;

endmodule

// File: tb/tb_crossing_request.sv
// Randomized and scenario-driven bench for crossing_request against a timestamp-based
// reference model of the request/dwell/pulse/acknowledge rules.
module tb_crossing_request;

  localparam int D = 4;
  localparam int M = 8;
  localparam int P = 2;
  localparam int A = 6;

  localparam int PH_IDLE  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_PULSE = 2;
  localparam int PH_WAIT  = 3;
  localparam int PH_CYCLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  crossing_request_if bus();

  crossing_request #(
    .DEBOUNCE_CYCLES(D),
    .MIN_RED_CYCLES (M),
    .PULSE_CYCLES   (P),
    .ACK_TIMEOUT    (A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state: raw samples, debounced level, timestamps of last events
  logic m_r1 = 1'b0, m_r2 = 1'b0, m_db = 1'b0, m_up = 1'b0;
  logic m_req = 1'b0, m_fault = 1'b0, m_start = 1'b0, m_busy = 1'b0;
  int   m_eq_t = 0, m_clear_t = 0, m_dwell = 0, m_phase = PH_IDLE, m_t_pulse = 0, m_t_wait = 0;

  // observed event bookkeeping
  logic prev_start = 1'b0, prev_req = 1'b0;
  int   n_pulses = 0, n_start_hi = 0, n_req_rise = 0, first_rise = -1, last_rise = -1, req_rise = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input int e);
    logic ro, mh, bs, rise, fault_old, req_old, timeout;
    int   nxt;
    ro = bus.red_light & !bus.yellow_light & !bus.green_light;
    mh = (bus.red_light & bus.yellow_light) | (bus.red_light & bus.green_light) |
         (bus.yellow_light & bus.green_light);
    if (rst) begin
      m_r1 = 1'b0; m_r2 = 1'b0; m_db = 1'b0; m_up = 1'b0;
      m_req = 1'b0; m_fault = 1'b0; m_start = 1'b0; m_busy = 1'b0;
      m_eq_t = e; m_clear_t = e; m_dwell = 0; m_phase = PH_IDLE;
      return;
    end
    fault_old = m_fault;
    req_old   = m_req;
    bs   = m_r2;
    m_r2 = m_r1;
    m_r1 = bus.raw_btn;
    rise = m_up;
    m_up = 1'b0;
    if (bs == m_db) m_eq_t = e;
    else if (e - m_eq_t >= D) begin
      m_db   = bs;
      m_eq_t = e;
      m_up   = bs;
    end
    nxt     = m_phase;
    timeout = 1'b0;
    case (m_phase)
      PH_ARMED: nxt = ro ? PH_PULSE : PH_IDLE;
      PH_PULSE: if (e - m_t_pulse == P) nxt = PH_WAIT;
      PH_WAIT: begin
        if (bus.green_light) nxt = PH_CYCLE;
        else if (e - m_t_wait == A) begin
          nxt     = PH_IDLE;
          timeout = 1'b1;
        end
      end
      PH_CYCLE: if (ro) nxt = PH_IDLE;
      default: ;
    endcase
    if (m_phase == PH_CYCLE || timeout || !ro) begin
      m_clear_t = e;
      m_dwell   = 0;
    end else begin
      m_dwell = (e - m_clear_t >= M) ? M : e - m_clear_t;
    end
    if (m_phase == PH_IDLE && req_old && m_dwell == M) nxt = PH_ARMED;
    if (fault_old) nxt = PH_IDLE;
    if (nxt == PH_PULSE && m_phase != PH_PULSE) m_t_pulse = e;
    if (nxt == PH_WAIT && m_phase != PH_WAIT) m_t_wait = e;
    if (rise) m_req = 1'b1;
    else if (m_phase == PH_WAIT && nxt == PH_CYCLE) m_req = 1'b0;
    m_fault = fault_old | mh;
    m_phase = nxt;
    m_start = (nxt == PH_PULSE);
    m_busy  = (nxt == PH_PULSE) || (nxt == PH_WAIT) || (nxt == PH_CYCLE);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    check_eq("start_btn", bus.start_btn, m_start);
    check_eq("req_pending", bus.req_pending, m_req);
    check_eq("busy", bus.busy, m_busy);
    check_eq("light_fault", bus.light_fault, m_fault);
    if (bus.start_btn) n_start_hi++;
    if (bus.start_btn && !prev_start) begin
      n_pulses++;
      last_rise = cyc;
      if (first_rise < 0) first_rise = cyc;
    end
    if (bus.req_pending && !prev_req) begin
      n_req_rise++;
      req_rise = cyc;
    end
    prev_start = bus.start_btn;
    prev_req   = bus.req_pending;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_lights(input logic r, input logic y, input logic g);
    bus.red_light    = r;
    bus.yellow_light = y;
    bus.green_light  = g;
  endtask

  task automatic clr_stats();
    n_pulses = 0; n_start_hi = 0; n_req_rise = 0;
    first_rise = -1; last_rise = -1; req_rise = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.raw_btn = 1'b0;
    run(2);
    check_eq("rst_start", bus.start_btn, 1'b0);
    check_eq("rst_req", bus.req_pending, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_fault", bus.light_fault, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int t0, r;
    logic btn_level;
    bus.raw_btn = 1'b0;
    set_lights(1'b0, 1'b0, 1'b0);

    // basic request with red already stable
    do_reset();
    set_lights(1'b1, 1'b0, 1'b0);
    run(20);
    clr_stats();
    t0 = cyc;
    bus.raw_btn = 1'b1;
    run(12);
    check_eq("t1_req_rise", req_rise, t0 + 7);
    check_eq("t1_start_rise", first_rise, t0 + 9);
    check_eq("t1_start_len", n_start_hi, P);
    set_lights(1'b0, 1'b0, 1'b1);
    step();
    check_eq("t1_req_clear", bus.req_pending, 1'b0);
    check_eq("t1_busy_cycle", bus.busy, 1'b1);
    run(3);
    set_lights(1'b1, 1'b0, 1'b0);
    step();
    check_eq("t1_busy_done", bus.busy, 1'b0);
    bus.raw_btn = 1'b0;
    run(10);

    // bouncing press settles into a single request
    do_reset();
    set_lights(1'b0, 1'b0, 1'b1);
    clr_stats();
    for (int i = 0; i < 10; i++) begin
      bus.raw_btn = ~bus.raw_btn;
      run(2);
    end
    t0 = cyc;
    bus.raw_btn = 1'b1;
    run(14);
    check_eq("t2_req_count", n_req_rise, 1);
    check_eq("t2_req_rise", req_rise, t0 + 7);
    bus.raw_btn = 1'b0;
    run(6);

    // minimum red dwell, then a yellow glitch restarting it
    for (int k = 0; k < 2; k++) begin
      do_reset();
      set_lights(1'b0, 1'b0, 1'b1);
      bus.raw_btn = 1'b1;
      run(10);
      bus.raw_btn = 1'b0;
      clr_stats();
      r = cyc;
      set_lights(1'b1, 1'b0, 1'b0);
      if (k == 1) begin
        run(4);
        set_lights(1'b0, 1'b1, 1'b0);
        step();
        set_lights(1'b1, 1'b0, 1'b0);
      end
      run(16);
      check_eq(k == 0 ? "t3_rise" : "t3_glitch_rise", first_rise, (k == 0) ? r + 9 : r + 14);
    end

    // no acknowledge: timeout, full new dwell, retry
    do_reset();
    set_lights(1'b1, 1'b0, 1'b0);
    run(10);
    clr_stats();
    t0 = cyc;
    bus.raw_btn = 1'b1;
    run(40);
    check_eq("t4_pulses", n_pulses, 2);
    check_eq("t4_first", first_rise, t0 + 9);
    check_eq("t4_retry", last_rise, t0 + 9 + P + A + 9);
    check_eq("t4_req_kept", bus.req_pending, 1'b1);

    // multi-hot lights latch the fault and block issue
    do_reset();
    set_lights(1'b1, 1'b0, 1'b0);
    run(10);
    set_lights(1'b1, 1'b0, 1'b1);
    step();
    set_lights(1'b1, 1'b0, 1'b0);
    step();
    check_eq("t5_fault_set", bus.light_fault, 1'b1);
    clr_stats();
    bus.raw_btn = 1'b1;
    run(30);
    check_eq("t5_no_pulse", n_pulses, 0);
    check_eq("t5_fault_sticky", bus.light_fault, 1'b1);
    do_reset();

    // reset during the first pulse cycle, then a normal request
    set_lights(1'b1, 1'b0, 1'b0);
    run(10);
    t0 = cyc;
    bus.raw_btn = 1'b1;
    run(9);
    check_eq("t6_in_pulse", bus.start_btn, 1'b1);
    rst = 1'b1;
    bus.raw_btn = 1'b0;
    step();
    check_eq("t6_start", bus.start_btn, 1'b0);
    check_eq("t6_req", bus.req_pending, 1'b0);
    check_eq("t6_busy", bus.busy, 1'b0);
    check_eq("t6_fault", bus.light_fault, 1'b0);
    rst = 1'b0;
    run(10);
    clr_stats();
    t0 = cyc;
    bus.raw_btn = 1'b1;
    run(12);
    check_eq("t6_req_rise", req_rise, t0 + 7);
    check_eq("t6_start_rise", first_rise, t0 + 9);

    // randomized lights, bouncy button and occasional resets against the model
    btn_level = 1'b0;
    for (int s = 0; s < 150; s++) begin
      int len, pick;
      len  = $urandom_range(1, 30);
      pick = $urandom_range(0, 99);
      if (pick < 55)      set_lights(1'b1, 1'b0, 1'b0);
      else if (pick < 72) set_lights(1'b0, 1'b0, 1'b1);
      else if (pick < 87) set_lights(1'b0, 1'b1, 1'b0);
      else if (pick < 96) set_lights(1'b0, 1'b0, 1'b0);
      else                set_lights(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      rst = ($urandom_range(0, 11) == 0);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) btn_level = ~btn_level;
        bus.raw_btn = ($urandom_range(0, 4) == 0) ? ~btn_level : btn_level;
        step();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
